piano_key_tracker: RTL
======================

# piano_key_tracker

Parametrised PS/2 scan-code interpreter for the piano design. It consumes the byte stream from the PS/2 receiver and tracks make/break (`F0`) and extended (`E0`) prefixes. It maintains a held-note bitmap of `12*OCTAVES` bits for the key renderer and audio path, and emits one-cycle note events. It sits between `Ps2Signals` and `PianoKeys`, replacing the switch-driven key vector, and also supplies the last two raw bytes for the seven-segment display.

## Interface
- `OCTAVES`, 2: octaves in the note bitmap; legal values are 2 to 8.
- `TIMEOUT_CYCLES`, 2_500_000: idle `mclk` cycles after which a pending prefix is discarded (50 ms at 50 MHz).
- `mclk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  one-cycle strobe; `in_data` is valid.
- `in_data`  in  8  received scan-code byte.
- `keys`  out  12*OCTAVES  held-note bitmap; bit n is note n, and bit 0 is the lowest C.
- `ev_valid`  out  1  one-cycle note-event strobe.
- `ev_press`  out  1  1 = press, 0 = release; valid with `ev_valid`.
- `ev_note`  out  ceil(log2(12*OCTAVES))  note index; valid with `ev_valid`.
- `octave`  out  3  window offset, range 0..OCTAVES-2.
- `last_byte`, `prev_byte`  out  8 each  newest and previous raw bytes, for display.

## Operation
- **Note mapping.** Bottom row Z S X D C V G B H N J M (`1A 1B 22 23 21 2A 34 32 33 31 3B 3A`) maps to window notes 0-11. Top row Q 2 W 3 E R 5 T 6 Y 7 U (`15 1E 1D 26 24 2D 2E 2C 36 35 3D 3C`) maps to window notes 12-23. Absolute note = window note + 12*`octave`.
- **FSM states:**
  - IDLE: `F0` goes to BRK; `E0` goes to EXT; a mapped code is a make; any other byte is ignored.
  - BRK: any byte goes to IDLE; a mapped code is a break.
  - EXT: `F0` goes to EXTBRK; any other byte goes to IDLE and is discarded.
  - EXTBRK: any byte goes to IDLE and is discarded. All extended keys are ignored.
- **Make:** sets the `keys` bit. An event fires only if the bit was 0. Typematic repeats produce no event.
- **Break:** clears the `keys` bit. An event fires only if the bit was 1.
- **Prefix timeout:** an idle counter resets on every `in_valid`. Reaching `TIMEOUT_CYCLES` in BRK, EXT or EXTBRK returns the FSM to IDLE with no other effect. The counter saturates and does not wrap.
- **Byte history:** every accepted byte, prefixes included, shifts `last_byte` into `prev_byte` and writes `in_data` into `last_byte`.
- **Reset:** `keys`=0, `ev_valid`=0, `ev_press`=0, `ev_note`=0, `octave`=0, `last_byte`=`prev_byte`=0, FSM=IDLE, timeout counter=0.

## Timing
- Each output is registered. `keys`, `ev_*` and the byte history update on the `mclk` edge after the cycle in which `in_valid` is high. Latency is one cycle.
- `ev_valid` is high for exactly one cycle per event, with at most one event per input byte. Back-to-back `in_valid` strobes are each processed; there is no stall and no backpressure.
- `rst` overrides `in_valid` in the same cycle.
- If `in_valid` is high in the cycle the counter would expire, the byte is processed in the current state and the timeout does not fire.

## Configuration
- `PIANO_OCTAVE_SHIFT_EN`, when defined:
  - `-` (`4E`) make decrements `octave`; `=` (`55`) make increments it.
  - `octave` saturates at 0 and at OCTAVES-2.
  - A successful shift clears all of `keys` in the same edge and emits no events.
  - Breaks of `4E` and `55` are ignored.
- When undefined: `octave` is tied to 0, `4E` and `55` are unmapped, and notes above 23 are never set.

## Structure
- `piano_pkg` holds:
  - prefix constants `SC_BREAK`=`8'hF0` and `SC_EXT`=`8'hE0`;
  - `SC_OCT_DN`/`SC_OCT_UP`;
  - the 24 note scan codes;
  - the FSM state enum.
- `piano_scancode_lut` is a combinational sub-module: input an 8-bit code; outputs `hit` and a 5-bit window note.

## Test plan
- **Press and release:** after reset, bytes `1A`, `F0 1A` give `keys`[0]=1 with event (press, 0), then `keys`[0]=0 with event (release, 0). `last_byte`=`1A`, `prev_byte`=`F0`.
- **Typematic repeat:** `15 15 15` gives `keys`[12]=1 and exactly one `ev_valid` pulse.
- **Extended keys ignored:** `E0 1A` then `E0 F0 1A` leave `keys` unchanged with no events; the FSM ends in IDLE.
- **Prefix timeout:** `F0`, idle `TIMEOUT_CYCLES` cycles, then `1A` is treated as a make, so `keys`[0]=1.
- **Octave shift:** with OCTAVES=4 and the macro defined:
  - `55 55 55` gives `octave`=2 (saturated);
  - `3C` then sets `keys`[47];
  - `4E` clears `keys` and gives `octave`=1.
- **Reset mid-sequence:** `rst` asserted between `F0` and `1A` returns everything to reset values; the following `1A` is a make.

Source files
------------

// File: rtl/piano_pkg.sv
// Shared scan-code constants and FSM state type for the PS/2 piano key tracker.
package piano_pkg;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_OCT_DN = 8'h4E;
  localparam logic [7:0] SC_OCT_UP = 8'h55;

  // Index is the window note: bottom row Z..M is 0-11, top row Q..U is 12-23.
  localparam logic [7:0] NOTE_CODES [24] = '{
    8'h1A, 8'h1B, 8'h22, 8'h23, 8'h21, 8'h2A, 8'h34, 8'h32, 8'h33, 8'h31, 8'h3B, 8'h3A,
    8'h15, 8'h1E, 8'h1D, 8'h26, 8'h24, 8'h2D, 8'h2E, 8'h2C, 8'h36, 8'h35, 8'h3D, 8'h3C
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BRK,
    ST_EXT,
    ST_EXTBRK
  } kb_state_e;

endpackage

// File: rtl/piano_scancode_lut.sv
// Combinational scan-code to window-note lookup for the 24 piano keys.
module piano_scancode_lut
  import piano_pkg::*;
(
  input  logic [7:0] code,
  output logic       hit,
  output logic [4:0] note
);

  always_comb begin
    hit  = 1'b0;
    note = 5'd0;
    for (int i = 0; i < 24; i++) begin
      if (code == NOTE_CODES[i]) begin
        hit  = 1'b1;
        note = 5'(i);
      end
    end
  end

endmodule

// File: rtl/piano_key_tracker.sv
// PS/2 scan-code interpreter: make/break/extended prefix FSM, held-note bitmap and note events.
// Optional octave shift on '-'/'=' keys is enabled by defining PIANO_OCTAVE_SHIFT_EN.
module piano_key_tracker
  import piano_pkg::*;
#(
  parameter int OCTAVES        = 2,
  parameter int TIMEOUT_CYCLES = 2_500_000
) (
  input  logic                            mclk,
  input  logic                            rst,
  input  logic                            in_valid,
  input  logic [7:0]                      in_data,
  output logic [12*OCTAVES-1:0]           keys,
  output logic                            ev_valid,
  output logic                            ev_press,
  output logic [$clog2(12*OCTAVES)-1:0]   ev_note,
  output logic [2:0]                      octave,
  output logic [7:0]                      last_byte,
  output logic [7:0]                      prev_byte
);

  localparam int NK = 12 * OCTAVES;
  localparam int NW = $clog2(NK);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  kb_state_e         state_q, state_d;
  logic [CW-1:0]     idle_cnt_q, idle_cnt_d;
  logic              expire;
  logic              lut_hit;
  logic [4:0]        lut_note;
  logic [2:0]        oct_base;
  logic [NW-1:0]     note_abs;
  logic              do_make, do_break;
  logic [NK-1:0]     keys_q, keys_d;
  logic              ev_valid_q, ev_valid_d;
  logic              ev_press_q, ev_press_d;
  logic [NW-1:0]     ev_note_q, ev_note_d;
  logic [7:0]        last_byte_q, last_byte_d;
  logic [7:0]        prev_byte_q, prev_byte_d;

`ifdef PIANO_OCTAVE_SHIFT_EN
  localparam logic [2:0] OCT_MAX = 3'(OCTAVES - 2);
  logic [2:0] octave_q, octave_d;
  logic       do_oct_dn, do_oct_up;
  assign oct_base = octave_q;
`else
  assign oct_base = 3'd0;
`endif

  piano_scancode_lut u_lut (
    .code (in_data),
    .hit  (lut_hit),
    .note (lut_note)
  );

  assign note_abs = NW'(int'(lut_note) + 12 * int'(oct_base));

  // An incoming byte always wins over an expiring prefix timeout.
  assign expire = (idle_cnt_q >= CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    if (in_valid)
      idle_cnt_d = '0;
    else if (idle_cnt_q == CW'(TIMEOUT_CYCLES))
      idle_cnt_d = idle_cnt_q;
    else
      idle_cnt_d = idle_cnt_q + CW'(1);
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idle_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (in_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (in_data == SC_BREAK)    state_d = ST_BRK;
          else if (in_data == SC_EXT) state_d = ST_EXT;
        end
        ST_EXT:  state_d = (in_data == SC_BREAK) ? ST_EXTBRK : ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end else if (expire) begin
      state_d = ST_IDLE;
    end
  end

  always_comb begin
    do_make  = 1'b0;
    do_break = 1'b0;
`ifdef PIANO_OCTAVE_SHIFT_EN
    do_oct_dn = 1'b0;
    do_oct_up = 1'b0;
`endif
    if (in_valid) begin
      case (state_q)
        ST_IDLE: begin
          do_make = lut_hit;
`ifdef PIANO_OCTAVE_SHIFT_EN
          do_oct_dn = (in_data == SC_OCT_DN);
          do_oct_up = (in_data == SC_OCT_UP);
`endif
        end
        ST_BRK:  do_break = lut_hit;
        default: ;
      endcase
    end
  end

  always_comb begin
    keys_d      = keys_q;
    ev_valid_d  = 1'b0;
    ev_press_d  = ev_press_q;
    ev_note_d   = ev_note_q;
    last_byte_d = last_byte_q;
    prev_byte_d = prev_byte_q;
    if (in_valid) begin
      prev_byte_d = last_byte_q;
      last_byte_d = in_data;
    end
    if (do_make) begin
      keys_d[note_abs] = 1'b1;
      if (!keys_q[note_abs]) begin
        ev_valid_d = 1'b1;
        ev_press_d = 1'b1;
        ev_note_d  = note_abs;
      end
    end
    if (do_break) begin
      keys_d[note_abs] = 1'b0;
      if (keys_q[note_abs]) begin
        ev_valid_d = 1'b1;
        ev_press_d = 1'b0;
        ev_note_d  = note_abs;
      end
    end
`ifdef PIANO_OCTAVE_SHIFT_EN
    octave_d = octave_q;
    if (do_oct_dn && octave_q != 3'd0) begin
      octave_d = octave_q - 3'd1;
      keys_d   = '0;
    end
    if (do_oct_up && octave_q < OCT_MAX) begin
      octave_d = octave_q + 3'd1;
      keys_d   = '0;
    end
`endif
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      keys_q      <= '0;
      ev_valid_q  <= 1'b0;
      ev_press_q  <= 1'b0;
      ev_note_q   <= '0;
      last_byte_q <= '0;
      prev_byte_q <= '0;
    end else begin
      keys_q      <= keys_d;
      ev_valid_q  <= ev_valid_d;
      ev_press_q  <= ev_press_d;
      ev_note_q   <= ev_note_d;
      last_byte_q <= last_byte_d;
      prev_byte_q <= prev_byte_d;
    end
  end

`ifdef PIANO_OCTAVE_SHIFT_EN
  always_ff @(posedge mclk) begin
    if (rst) octave_q <= 3'd0;
    else     octave_q <= octave_d;
  end
  assign octave = octave_q;
`else
  assign octave = 3'd0;
`endif

  assign keys      = keys_q;
  assign ev_valid  = ev_valid_q;
  assign ev_press  = ev_press_q;
  assign ev_note   = ev_note_q;
  assign last_byte = last_byte_q;
  assign prev_byte = prev_byte_q;

endmodule
